// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered count, occupancy flags and one-cycle overflow/underflow pulses.
// Latency: rd_data registered one cycle after an accepted read; with PARAM_SYNC_FIFO_FWFT_EN the head word shows whenever not empty.
// Backpressure: writes are dropped while full and reads are ignored while empty; each dropped access raises an error pulse.
module param_sync_fifo #(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Flags decode only the registered count, so they never depend on this cycle's requests.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem[wr_ptr] <= wr_data;
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign rd_data = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_acc) begin
      rd_data <= mem[rd_ptr];
    end
  end
`endif

endmodule
